router_fifo: RTL and testbench
==============================

# router_fifo

Per-destination output FIFO of the 1x3 router. It sits directly downstream of `router_register`: it captures each byte the register drives on its `dout` bus, tagged with the FSM's `lfd_state` so the header byte is marked, and presents packets in order to the destination's read port. It tracks the remaining byte count of the packet being read from the header's length field. The top level instantiates three copies.

## Interface
- `DEPTH`, 16, number of entries; must be a power of two, at least 4.
- `WIDTH`, 8, data byte width. Stored word is `WIDTH+1` bits: bit `WIDTH` is the header flag.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `soft_reset`  in  1  synchronous flush from the synchronizer timeout, active-high.
- `write_enb`  in  1  write request for the current cycle.
- `read_enb`  in  1  read request for the current cycle.
- `lfd_state`  in  1  the byte being written is a header; stored as the header flag.
- `data_in`  in  WIDTH  byte from `router_register` `dout`.
- `data_out`  out  WIDTH  registered read data.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `pkt_active`  out  1  a packet read is in progress (remaining count non-zero).

## Operation
- Pointers: write pointer and read pointer, each log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Address wraps modulo DEPTH.
- `empty` is true when the two pointers are equal. `full` is true when the MSBs differ and the address bits are equal. Both are combinational from the registered pointers.
- Write: when `write_enb` is high and `full` is low, store {`lfd_state`, `data_in`} at the write pointer, then increment the write pointer. A write while full is dropped silently.
- Read: when `read_enb` is high and `empty` is low, load `data_out` with the stored byte, then increment the read pointer. A read while empty is ignored and `data_out` holds its value.
- Remaining-count register `rcnt`, 7 bits:
  - On a read of a flagged word, `rcnt` loads `stored[7:2] + 1` (payload length plus parity).
  - On a read of an unflagged word, `rcnt` decrements if non-zero and saturates at 0.
- `pkt_active` is `rcnt != 0`.
- Simultaneous read and write:
  - Both are evaluated against the pre-edge `full`/`empty`.
  - When full, the read happens and the write is dropped.
  - When empty, the write happens and the read is ignored.
  - Otherwise both happen and the occupancy is unchanged.
- `soft_reset` (synchronous) has priority over read and write in the same cycle. It clears both pointers, `rcnt` and `data_out`. Memory contents are don't-care.
- `rst` (asynchronous) clears the same state immediately.
- Reset values: `data_out`=0, `full`=0, `empty`=1, `pkt_active`=0.

## Timing
- Write-to-empty deassert: `empty` falls the cycle after the accepting edge.
- Read latency is 1 cycle: `data_out` is valid after the edge that samples `read_enb`.
- `full` rises after the edge that accepts the DEPTH-th write. It falls after the edge that accepts a read.
- `rcnt` updates on the same edge as `data_out`. For a length-5 header, `rcnt` goes 6 after the header, 5 after the first payload byte, and 0 after the parity byte.
- Throughput is one write and one read per cycle, sustained.
- Asserting `rst` mid-packet takes effect asynchronously. No partial state survives, and `pkt_active` drops at once.

## Structure
- Shared package `router_pkg` holds:
  - `ADDR_LSB`=0, `ADDR_MSB`=1, `LEN_LSB`=2, `LEN_MSB`=7;
  - the `FIFO_DEPTH` default;
  - the stored-word type with the header-flag position.
  
  `router_register` and `router_fsm` use the same package.
- Sub-module `router_fifo_mem` is a simple dual-port array: one synchronous write port and one synchronous read port with no reset. The pointer, flag and count logic stays in `router_fifo`.

## Test plan
1. Reset with `rst`=1 → `empty`=1, `full`=0, `data_out`=0, `pkt_active`=0. Release `rst` → same values.
2. Write a packet:
   - header 0x16 (length 5, address 2) with `lfd_state`=1;
   - payload 0x00..0x04;
   - parity 0x12.
   
   Then read 7 times → `data_out` sequence 0x16,0,1,2,3,4,0x12, each one cycle after its read. `rcnt` sequence 6,5,4,3,2,1,0. `pkt_active` falls after the parity byte. `empty`=1 at the end.
3. Write 17 bytes 0x00..0x10 → `full`=1 after the 16th write and 0x10 is dropped. Read 16 → 0x00..0x0F, then `empty`=1. Repeat the pattern to cover pointer wrap-around.
4. Read on empty → `data_out` holds its last value and the pointers do not move. Write on full → occupancy stays 16.
5. Assert `read_enb` and `write_enb` together:
   - when full, one byte leaves, the new byte is dropped and `full` falls;
   - when empty, the byte is stored, `data_out` is unchanged and `empty` falls;
   - at mid-occupancy, the count is unchanged.
6. Assert `soft_reset` mid-packet (after 3 bytes of 7 have been read), together with a write → next cycle `empty`=1, `pkt_active`=0, `data_out`=0, and the write is discarded. Assert `rst` asynchronously mid-packet → outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router blocks (router_register, router_fsm,
// router_fifo).
//   - Header byte field positions (address and payload length).
//   - Default FIFO geometry.
//   - Stored FIFO word layout: header flag above the data byte.
//   - Helper that advances the remaining-byte count on each FIFO read.
package router_pkg;

  localparam int ADDR_LSB   = 0;
  localparam int ADDR_MSB   = 1;
  localparam int LEN_LSB    = 2;
  localparam int LEN_MSB    = 7;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 8;
  localparam int HDR_BIT    = FIFO_WIDTH;

  typedef struct packed {
    logic                  hdr;
    logic [FIFO_WIDTH-1:0] data;
  } fifo_word_t;

  // Remaining-count update for one read.
  // - A header loads payload length plus one, so the parity byte is counted.
  // - Any other byte counts down and saturates at zero.
  function automatic logic [6:0] next_rcnt(input logic [6:0] cur,
                                           input logic       hdr,
                                           input logic [5:0] len);
    logic [6:0] nxt;
    if (hdr) begin
      nxt = {1'b0, len} + 7'd1;
    end else if (cur != 7'd0) begin
      nxt = cur - 7'd1;
    end else begin
      nxt = 7'd0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Bus between a router_fifo and its producer/consumer.
//
// Handshake semantics:
// - A write is accepted on a rising edge when write_enb=1 and full=0.
// - A read is accepted on a rising edge when read_enb=1 and empty=0.
// - Both conditions are judged on pre-edge flags.
// - Requests that are not accepted are dropped, not held.
// - soft_reset flushes the FIFO and overrides both requests in the same cycle.
//
// Modports:
// - master: the side that issues requests.
// - slave:  the FIFO itself.
interface router_fifo_if #(parameter int WIDTH = 8);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_active;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_active
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_active
  );
endinterface

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage array for router_fifo.
// Ports:
// - clk:     rising-edge clock.
// - wr_en / wr_addr / wr_data: synchronous write port.
// - rd_en / rd_addr:           synchronous read port.
// - rd_data: registered read data; loads only when rd_en=1, holds otherwise.
// The array has no reset; the pointer logic in router_fifo decides which
// contents are meaningful.
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 9,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router.
// Bytes are captured from router_register, with the header byte flagged.
// Packets are presented in order to the read port.
//
// Ports:
// - clk: rising-edge clock.
// - rst: asynchronous active-high reset.
// - bus: router_fifo_if.slave
//   - inputs:  soft_reset, write_enb, read_enb, lfd_state, data_in
//   - outputs: data_out, full, empty, pkt_active
//
// The remaining-byte count of the packet being read is held in rcnt;
// pkt_active reports whether it is non-zero.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  router_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           out_clr_q, out_clr_d;
  logic           fresh_q, fresh_d;
  logic [6:0]     rcnt_base_q, rcnt_base_d;
  logic [6:0]     rcnt;
  logic           full, empty, do_wr, do_rd;
  logic [WIDTH:0] rd_word;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_wr = bus.write_enb && !full  && !bus.soft_reset;
  assign do_rd = bus.read_enb  && !empty && !bus.soft_reset;

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (WIDTH + 1),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data ({bus.lfd_state, bus.data_in}),
    .rd_en   (do_rd),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_word)
  );

  // The array's read register has no reset.
  // - out_clr_q forces data_out to zero after any reset, until the next read.
  // - The read word appears only after the read edge, so the count is split:
  //   rcnt_base_q holds the count before the newest read.
  //   fresh_q says that read still has to be applied.
  // - rcnt therefore changes on the same edge as data_out, and async reset
  //   clears it at once.
  always_comb begin
    rcnt = rcnt_base_q;
    if (fresh_q) begin
      rcnt = next_rcnt(rcnt_base_q, rd_word[WIDTH], rd_word[LEN_MSB:LEN_LSB]);
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_clr_d   = out_clr_q;
    rcnt_base_d = rcnt;
    fresh_d     = do_rd;
    if (bus.soft_reset) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_clr_d   = 1'b1;
      rcnt_base_d = 7'd0;
      fresh_d     = 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        out_clr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_clr_q   <= 1'b1;
      rcnt_base_q <= 7'd0;
      fresh_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_clr_q   <= out_clr_d;
      rcnt_base_q <= rcnt_base_d;
      fresh_q     <= fresh_d;
    end
  end

  assign bus.data_out   = out_clr_q ? '0 : rd_word[WIDTH-1:0];
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.pkt_active = (rcnt != 7'd0);

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [7:0] exp_dout;
  logic [6:0] exp_rcnt;
  int         checks;
  int         failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".dout"},  bus.data_out,   exp_dout);
    check_eq({tag, ".full"},  bus.full,       exp_q.size() == DEPTH);
    check_eq({tag, ".empty"}, bus.empty,      exp_q.size() == 0);
    check_eq({tag, ".pkt"},   bus.pkt_active, exp_rcnt != 0);
    check_eq({tag, ".rcnt"},  dut.rcnt,       exp_rcnt);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_dout = 8'h00;
    exp_rcnt = 7'd0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of requests and advances the model on the same edge.
  // Outputs are compared 1 ns after the edge.
  task automatic drive_cycle(input logic we, input logic re, input logic lfd,
                             input logic [7:0] din, input logic sr, input string tag);
    logic       acc_wr, acc_rd;
    logic [8:0] w;
    bus.write_enb  = we;
    bus.read_enb   = re;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    bus.soft_reset = sr;
    acc_rd = re && (exp_q.size() != 0) && !sr;
    acc_wr = we && (exp_q.size() != DEPTH) && !sr;
    @(posedge clk);
    if (sr) begin
      model_reset();
    end else begin
      if (acc_rd) begin
        w = exp_q.pop_front();
        exp_dout = w[7:0];
        if (w[8])              exp_rcnt = {1'b0, w[7:2]} + 7'd1;
        else if (exp_rcnt != 0) exp_rcnt = exp_rcnt - 7'd1;
      end
      if (acc_wr) exp_q.push_back({lfd, din});
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic write_byte(input logic lfd, input logic [7:0] din);
    drive_cycle(1'b1, 1'b0, lfd, din, 1'b0, "wr");
  endtask

  task automatic read_byte();
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "rd");
  endtask

  task automatic write_packet();
    write_byte(1'b1, 8'h16);
    for (int i = 0; i < 5; i++) write_byte(1'b0, 8'(i));
    write_byte(1'b0, 8'h12);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pkt_tbl  [7];
  logic [6:0] rcnt_tbl [7];

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    pkt_tbl  = '{8'h16, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h12};
    rcnt_tbl = '{7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;

    // 1. Reset values while held and after release
    #3;
    check_outputs("rst_held");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("rst_rel");

    // 2. One packet in, seven reads out
    write_packet();
    for (int i = 0; i < 7; i++) begin
      read_byte();
      check_eq("pkt_dout", bus.data_out, pkt_tbl[i]);
      check_eq("pkt_rcnt", dut.rcnt, rcnt_tbl[i]);
    end
    check_eq("pkt_end_empty", bus.empty, 1'b1);
    check_eq("pkt_end_active", bus.pkt_active, 1'b0);

    // 3. Fill to full, one extra write dropped, drain; twice for wrap-around
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 17; i++) begin
        write_byte(1'b0, 8'(i));
        if (i == 15) check_eq("full_after_16", bus.full, 1'b1);
      end
      for (int i = 0; i < 16; i++) begin
        read_byte();
        check_eq("drain_dout", bus.data_out, 8'(i));
      end
      check_eq("drain_empty", bus.empty, 1'b1);
    end

    // 4. Read on empty holds data_out; write on full holds occupancy
    read_byte();
    read_byte();
    check_eq("empty_hold", bus.data_out, 8'h0F);
    for (int i = 0; i < 18; i++) write_byte(1'b0, 8'(8'h40 + i));
    check_eq("full_hold", bus.full, 1'b1);

    // 5. Simultaneous read and write
    drive_cycle(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, "rw_full");
    check_eq("rw_full_dout", bus.data_out, 8'h40);
    check_eq("rw_full_fall", bus.full, 1'b0);
    for (int i = 0; i < 15; i++) read_byte();
    check_eq("rw_full_last", bus.data_out, 8'h4F);
    drive_cycle(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, "rw_empty");
    check_eq("rw_empty_dout", bus.data_out, 8'h4F);
    check_eq("rw_empty_fall", bus.empty, 1'b0);
    for (int i = 0; i < 4; i++) write_byte(1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'(8'h70 + i), 1'b0, "rw_mid");
    while (exp_q.size() != 0) read_byte();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 63) == 0), "rand");
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "flush");

    // 6a. soft_reset mid-packet together with a write
    write_packet();
    for (int i = 0; i < 3; i++) read_byte();
    check_eq("sr_pre_active", bus.pkt_active, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, "sr");
    check_eq("sr_empty", bus.empty, 1'b1);
    check_eq("sr_active", bus.pkt_active, 1'b0);
    check_eq("sr_dout", bus.data_out, 8'h00);
    read_byte();

    // 6b. Asynchronous rst mid-packet, checked before the next clock edge
    write_packet();
    for (int i = 0; i < 3; i++) read_byte();
    bus.read_enb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("async_rel");
    write_packet();
    read_byte();
    check_eq("post_rst_hdr", bus.data_out, 8'h16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
